// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: op codes, funct encodings
// and the two-state FSM encoding.
package alu_ctrl_pkg;

    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned OP_W    = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV = 4'b0011;
    localparam logic [OP_W-1:0] OP_AND = 4'b0100;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0101;
    localparam logic [OP_W-1:0] OP_NOR = 4'b0110;
    localparam logic [OP_W-1:0] OP_NOP = 4'b0111;
    localparam logic [OP_W-1:0] OP_SRL = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLT = 4'b1001;
    localparam logic [OP_W-1:0] OP_XOR = 4'b1010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_MUL = 6'b000010;
    localparam logic [FUNCT_W-1:0] FN_DIV = 6'b011010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] FN_NOP = 6'b000000;
    localparam logic [FUNCT_W-1:0] FN_SRL = 6'b000011;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_XOR = 6'b100110;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_EXEC = 1'b1;

endpackage

// File: rtl/alu_funct_dec.sv
// Combinational funct decoder: op code, undefined-funct flag and multi-cycle hint.
module alu_funct_dec
    import alu_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    input  logic               rtype,
    output logic [OP_W-1:0]    op_c,
    output logic               illegal_c,
    output logic               multi_c
);

    // Non-R-type instructions always compute an address, so funct is ignored.
    always_comb begin
        op_c      = OP_ADD;
        illegal_c = 1'b0;
        multi_c   = 1'b0;
        if (rtype) begin
            case (funct)
                FN_ADD:  op_c = OP_ADD;
                FN_SUB:  op_c = OP_SUB;
                FN_MUL: begin
                    op_c    = OP_MUL;
                    multi_c = 1'b1;
                end
                FN_DIV: begin
                    op_c    = OP_DIV;
                    multi_c = 1'b1;
                end
                FN_AND:  op_c = OP_AND;
                FN_OR:   op_c = OP_OR;
                FN_NOR:  op_c = OP_NOR;
                FN_NOP:  op_c = OP_NOP;
                FN_SRL:  op_c = OP_SRL;
                FN_SLT:  op_c = OP_SLT;
                FN_XOR:  op_c = OP_XOR;
                default: illegal_c = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes an instruction, issues a registered op code and
// holds it for the MUL/DIV occupancy while blocking new instructions.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               rtype,
    output logic [OP_W-1:0]    alu_op,
    output logic               op_valid,
    output logic               busy,
    output logic               done,
    output logic               illegal
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [OP_W-1:0]   alu_op_nxt;
    logic              op_valid_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              illegal_nxt;

    logic [OP_W-1:0]   dec_op;
    logic              dec_illegal;
    logic              dec_multi;
    logic [CNT_W-1:0]  lat_last;

    alu_funct_dec u_dec (
        .funct     (instr[FUNCT_W-1:0]),
        .rtype     (rtype),
        .op_c      (dec_op),
        .illegal_c (dec_illegal),
        .multi_c   (dec_multi)
    );

    // Only the funct field is decoded; upper instruction bits are intentionally dropped.
    if (INSTR_W > FUNCT_W) begin : g_instr_hi
        logic unused_instr_hi;
        assign unused_instr_hi = ^instr[INSTR_W-1:FUNCT_W];
    end

    assign lat_last = (dec_op == OP_DIV) ? DIV_LAST : MUL_LAST;
    assign in_ready = (state == ST_IDLE);

    // Next state and next register values; non-accepting IDLE cycles hold alu_op.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        alu_op_nxt   = alu_op;
        illegal_nxt  = illegal;
        op_valid_nxt = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    alu_op_nxt   = dec_op;
                    illegal_nxt  = dec_illegal;
                    op_valid_nxt = 1'b1;
                    if (dec_multi && (lat_last != '0)) begin
                        state_nxt = ST_EXEC;
                        cnt_nxt   = lat_last;
                        busy_nxt  = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                // Counter reaching zero marks the done cycle; the following edge releases.
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt      = cnt - CNT_W'(1);
                    op_valid_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                    done_nxt     = (cnt == CNT_W'(1));
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            alu_op   <= OP_NOP;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            alu_op   <= alu_op_nxt;
            op_valid <= op_valid_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            illegal  <= illegal_nxt;
        end
    end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 The block SHALL have parameter INSTR_W, default 32, meaning instruction width; the funct field is instr[5:0] and INSTR_W SHALL be at least 6.
REQ-002 The block SHALL have parameter MUL_LAT, default 3, meaning MUL occupancy in cycles; it SHALL be at least 1.
REQ-003 The block SHALL have parameter DIV_LAT, default 8, meaning DIV occupancy in cycles; it SHALL be at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: instruction offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept.
REQ-008 The block SHALL have port instr, input, INSTR_W bits: instruction word.
REQ-009 The block SHALL have port rtype, input, 1 bit: 1 selects funct decode; 0 forces ADD (load/store address calculation).
REQ-010 The block SHALL have port alu_op, output, 4 bits: registered ALU operation code.
REQ-011 The block SHALL have port op_valid, output, 1 bit: alu_op is valid for the ALU this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse marking operation completion.
REQ-014 The block SHALL have port illegal, output, 1 bit: registered flag for an undefined funct; valid while op_valid=1.

Function
REQ-015 The decode SHALL map funct to alu_op as follows: 100000→0000 ADD; 100010→0001 SUB; 000010→0010 MUL; 011010→0011 DIV; 100100→0100 AND; 100101→0101 OR; 100111→0110 NOR; 000000→0111 NOP; 000011→1000 SRL; 101010→1001 SLT; 100110→1010 XOR.
REQ-016 Any other funct with rtype=1 SHALL produce alu_op=0000 and illegal=1, executed single-cycle.
REQ-017 rtype=0 SHALL produce alu_op=0000, illegal=0, single-cycle, with funct ignored.
REQ-018 The block SHALL have exactly two states: IDLE and EXEC.
REQ-019 in_ready SHALL be 1 in IDLE and 0 in EXEC, decoded from state with no dependence on in_valid.
REQ-020 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_valid in EXEC SHALL be ignored.
REQ-021 For a single-cycle op accepted at edge N: alu_op and illegal SHALL update, and op_valid=1 and done=1, for exactly the cycle after edge N; state SHALL stay IDLE.
REQ-022 Back-to-back single-cycle ops SHALL be accepted every cycle, giving continuous op_valid.
REQ-023 MUL or DIV with LAT>1, accepted at edge N: the state SHALL go to EXEC and the cycle counter SHALL load LAT-1.
REQ-024 In EXEC, busy=1 and op_valid=1 SHALL hold, alu_op SHALL be held stable, and the counter SHALL decrement each edge.
REQ-025 While counter=0 in EXEC, done SHALL be 1; the next edge SHALL return the state to IDLE.
REQ-026 Total op_valid duration for a multi-cycle op SHALL be exactly LAT cycles, with in_ready low for those same LAT cycles.
REQ-027 MUL or DIV with LAT=1 SHALL behave as single-cycle per REQ-021.
REQ-028 With no acceptance in IDLE, op_valid, done and busy SHALL be 0 on the following cycle, and alu_op SHALL hold its last value.
REQ-029 The counter width SHALL be $clog2(max(MUL_LAT,DIV_LAT)) with a minimum of 1, and the counter SHALL never wrap below 0.

Reset
REQ-030 Asserting rst SHALL immediately set: state=IDLE, counter=0, alu_op=0111 (NOP), op_valid=0, busy=0, done=0, illegal=0.
REQ-031 in_ready SHALL be 1 during and after reset.
REQ-032 Reset during EXEC SHALL abort the operation with no done pulse; the first edge after release MAY accept a new instruction.

Structure
REQ-033 Package alu_ctrl_pkg SHALL hold the op-code constants, funct constants and the state type.
REQ-034 A combinational sub-module alu_funct_dec SHALL map (funct, rtype) to (op, illegal, multi).
REQ-035 The top level SHALL hold the FSM, the counter and the output registers.

Verification
REQ-036 Reset, rtype=1, funct=100010 accepted: the next cycle SHALL show alu_op=0001, op_valid=1, done=1, busy=0, in_ready=1.
REQ-037 Five back-to-back ops ADD, AND, OR, XOR, SLT: op_valid SHALL stay high for 5 consecutive cycles with codes 0000, 0100, 0101, 1010, 1001 in order.
REQ-038 DIV (011010) with DIV_LAT=8 while in_valid stays high with an ADD queued: busy=1 and in_ready=0 SHALL hold for 8 cycles with done only in the 8th; the ADD SHALL be accepted on the edge after.
REQ-039 funct=111111 with rtype=1 SHALL give alu_op=0000, illegal=1; rtype=0 with funct=000010 SHALL give alu_op=0000, illegal=0, single-cycle.
REQ-040 MUL with MUL_LAT=3, rst asserted in EXEC cycle 2: outputs SHALL reset asynchronously, no done SHALL appear, and in_ready SHALL be 1 after release.
REQ-041 Rerun with MUL_LAT=1 and INSTR_W=16: MUL SHALL complete single-cycle and the decode SHALL be unchanged.
